ws2812_decoder: RTL and testbench
=================================

WS2812_DECODER -- requirements
Module: ws2812_decoder

Interface
REQ-001 SHALL have parameter LENGTH, default 4, meaning number of pixels held in the frame buffer.
REQ-002 SHALL have parameter MIN_HIGH, default 5, meaning the minimum high-pulse cycles for a valid bit; shorter pulses are glitches.
REQ-003 SHALL have parameter BIT_THRESH, default 30, meaning high-pulse cycles at or above which a bit decodes as 1.
REQ-004 SHALL have parameter MAX_HIGH, default 60, meaning high-pulse cycles at which the line is treated as stuck high.
REQ-005 SHALL have parameter LATCH_CYCLES, default 2500, meaning low cycles that end a frame (50 us at 50 MHz).
REQ-006 SHALL have port clk, input, 1 bit: single 50 MHz clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port DI, input, 1 bit: asynchronous serial pixel line.
REQ-009 SHALL have port pixel_data, output, 24 bits: last completed pixel word.
REQ-010 SHALL have port pixel_valid, output, 1 bit: one-cycle pulse when pixel_data is updated.
REQ-011 SHALL have port pixel_index, output, 8 bits: index of the pixel in pixel_data within the frame.
REQ-012 SHALL have port strip, output, LENGTH*24 bits: frame buffer; pixel N occupies strip[24N+23:24N].
REQ-013 SHALL have port frame_done, output, 1 bit: one-cycle pulse when strip is updated.
REQ-014 SHALL have port frame_pixels, output, 8 bits: completed pixels in the last frame, saturating at 255.
REQ-015 SHALL have port error, output, 1 bit: one-cycle pulse on a glitch, stuck-high, or partial-pixel event.

Function
REQ-016 SHALL synchronize DI through 2 flops to din_s; all timing below counts din_s cycles.
REQ-017 SHALL implement the states WAIT_LATCH, IDLE, HIGH and LOW.
REQ-018 WAIT_LATCH: counts consecutive low cycles, clears on high, and enters IDLE at LATCH_CYCLES with no frame_done.
REQ-019 IDLE: a din_s rising edge enters HIGH and clears the high counter.
REQ-020 HIGH: the high counter increments each cycle and saturates at MAX_HIGH.
REQ-021 If the high counter reaches MAX_HIGH: error pulse, current frame discarded, go to WAIT_LATCH.
REQ-022 On a falling edge with count < MIN_HIGH: error pulse, bit discarded, go to LOW.
REQ-023 On a falling edge with count >= MIN_HIGH: bit = (count >= BIT_THRESH), shifted in MSB-first, go to LOW.
REQ-024 The first bit of a frame SHALL land in bit 23 of pixel 0.
REQ-025 LOW: the low counter (12 bits, saturating) increments, and a rising edge goes to HIGH with the low counter cleared.
REQ-026 In LOW, when the low counter reaches LATCH_CYCLES, the decoder SHALL end the frame and go to IDLE.
REQ-027 On the 24th bit of a word: pixel_data and pixel_index update and pixel_valid pulses on the same cycle the bit is registered.
REQ-028 The 24th-bit update SHALL also write the word to the shadow buffer at pixel_index if pixel_index < LENGTH, and reset the bit count.
REQ-029 Latency: pixel_valid SHALL assert 3 clk after the raw DI falling edge of the 24th bit.
REQ-030 Pixels with index >= LENGTH SHALL still pulse pixel_valid but SHALL NOT write the buffer.
REQ-031 Frame end: frame_done pulses, strip <= shadow, frame_pixels <= completed count, and the pixel index resets to 0.
REQ-032 Shadow entries not written in a frame SHALL retain their previous values.
REQ-033 Frame end with a partial word (bit count != 0): partial bits dropped, error pulses in the same cycle as frame_done.
REQ-034 The error, pixel_valid and frame_done pulses SHALL each assert for exactly 1 cycle per event.
REQ-035 Simultaneous error and pixel_valid SHALL both assert.

Reset
REQ-036 While reset is high the decoder SHALL be in WAIT_LATCH with all counters 0.
REQ-037 While reset is high, pixel_data=0, pixel_index=0, strip=0, shadow=0 and frame_pixels=0.
REQ-038 While reset is high, pixel_valid=0, frame_done=0 and error=0.
REQ-039 Reset asserted mid-frame SHALL discard all partial data; strip SHALL NOT update.
REQ-040 After reset the decoder SHALL ignore DI activity until LATCH_CYCLES of continuous low.

Verification
REQ-041 Reset, 2500 low, then 4 pixels FF0000, 00FF00, 0000FF, FFFFFF (bit 1 = 40 high/21 low, bit 0 = 20 high/41 low), then 2500 low -> 4 pixel_valid with indices 0..3, frame_done, strip = 96'hFFFFFF_0000FF_00FF00_FF0000, frame_pixels=4.
REQ-042 High pulses of 29 and 30 cycles -> decoded 0 and 1 respectively; a 4-cycle pulse -> error, no bit shifted.
REQ-043 6 pixels sent with LENGTH=4 -> 6 pixel_valid, strip holds pixels 0..3 only, frame_pixels=6.
REQ-044 30 bits then latch -> 1 pixel_valid, frame_done with error in the same cycle, frame_pixels=1, only pixel 0 updated.
REQ-045 DI held high 60 cycles mid-frame -> error, no frame_done; the next valid frame after 2500 low decodes correctly.
REQ-046 Reset asserted after 12 pixel bits -> strip stays 0, and bits sent before 2500 low are ignored.

Source files
------------

// File: rtl/ws2812_decoder.sv
// ws2812_decoder: WS2812 serial line decoder with pixel stream, frame buffer and error pulses.
module ws2812_decoder #(
   parameter int LENGTH       = 4,
   parameter int MIN_HIGH     = 5,
   parameter int BIT_THRESH   = 30,
   parameter int MAX_HIGH     = 60,
   parameter int LATCH_CYCLES = 2500
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  DI,
   output logic [23:0]           pixel_data,
   output logic                  pixel_valid,
   output logic [7:0]            pixel_index,
   output logic [LENGTH*24-1:0]  strip,
   output logic                  frame_done,
   output logic [7:0]            frame_pixels,
   output logic                  error
);
   typedef enum logic [1:0] {WAIT_LATCH, IDLE, HIGH, LOW} state_t;
   localparam logic [7:0]  MIN_H = 8'(MIN_HIGH);
   localparam logic [7:0]  THR_H = 8'(BIT_THRESH);
   localparam logic [7:0]  MAX_H = 8'(MAX_HIGH);
   localparam logic [11:0] LAT_L = 12'(LATCH_CYCLES);
   state_t                   state_q, state_d;
   logic                     di_m_q, di_m_d, din_s_q, din_s_d;
   logic [7:0]               hcnt_q, hcnt_d, pidx_q, pidx_d;
   logic [11:0]              lcnt_q, lcnt_d;
   logic [4:0]               bcnt_q, bcnt_d;
   logic [22:0]              shift_q, shift_d;
   logic [LENGTH-1:0][23:0]  shadow_q, shadow_d, strip_q, strip_d;
   logic [23:0]              pixel_data_q, pixel_data_d;
   logic [7:0]               pixel_index_q, pixel_index_d, frame_pixels_q, frame_pixels_d;
   logic                     pixel_valid_q, pixel_valid_d, frame_done_q, frame_done_d, error_q, error_d;
   logic [7:0]               hinc;
   logic [11:0]              linc;
   logic [23:0]              word;
   always_comb begin
      di_m_d         = DI;
      din_s_d        = di_m_q;
      state_d        = state_q;
      hcnt_d         = hcnt_q;
      lcnt_d         = lcnt_q;
      bcnt_d         = bcnt_q;
      shift_d        = shift_q;
      pidx_d         = pidx_q;
      shadow_d       = shadow_q;
      strip_d        = strip_q;
      pixel_data_d   = pixel_data_q;
      pixel_index_d  = pixel_index_q;
      frame_pixels_d = frame_pixels_q;
      pixel_valid_d  = 1'b0;
      frame_done_d   = 1'b0;
      error_d        = 1'b0;
      hinc           = hcnt_q + 8'd1;
      linc           = (lcnt_q == 12'hFFF) ? lcnt_q : lcnt_q + 12'd1;
      word           = {shift_q, hcnt_q >= THR_H};
      case (state_q)
         WAIT_LATCH: begin
            lcnt_d = din_s_q ? 12'd0 : linc;
            if (!din_s_q && linc >= LAT_L) begin
               state_d = IDLE;
               lcnt_d  = 12'd0;
            end
         end
         IDLE: begin
            if (din_s_q) begin
               state_d = HIGH;
               hcnt_d  = 8'd1;
               lcnt_d  = 12'd0;
            end
         end
         HIGH: begin
            if (din_s_q) begin
               hcnt_d = hinc;
               // Stuck line: drop the frame and roll the shadow back to the last shown strip
               if (hinc >= MAX_H) begin
                  error_d  = 1'b1;
                  state_d  = WAIT_LATCH;
                  hcnt_d   = 8'd0;
                  lcnt_d   = 12'd0;
                  bcnt_d   = 5'd0;
                  shift_d  = '0;
                  pidx_d   = 8'd0;
                  shadow_d = strip_q;
               end
            end else begin
               state_d = LOW;
               lcnt_d  = 12'd1;
               if (hcnt_q < MIN_H) begin
                  error_d = 1'b1;
               end else if (bcnt_q == 5'd23) begin
                  pixel_data_d  = word;
                  pixel_index_d = pidx_q;
                  pixel_valid_d = 1'b1;
                  for (int i = 0; i < LENGTH; i++)
                     if (pidx_q == 8'(i)) shadow_d[i] = word;
                  bcnt_d  = 5'd0;
                  shift_d = '0;
                  pidx_d  = (pidx_q == 8'hFF) ? pidx_q : pidx_q + 8'd1;
               end else begin
                  shift_d = word[22:0];
                  bcnt_d  = bcnt_q + 5'd1;
               end
            end
         end
         LOW: begin
            if (din_s_q) begin
               state_d = HIGH;
               hcnt_d  = 8'd1;
               lcnt_d  = 12'd0;
            end else begin
               lcnt_d = linc;
               if (linc >= LAT_L) begin
                  state_d        = IDLE;
                  lcnt_d         = 12'd0;
                  frame_done_d   = 1'b1;
                  strip_d        = shadow_q;
                  frame_pixels_d = pidx_q;
                  error_d        = bcnt_q != 5'd0;
                  bcnt_d         = 5'd0;
                  shift_d        = '0;
                  pidx_d         = 8'd0;
               end
            end
         end
         default: state_d = WAIT_LATCH;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= WAIT_LATCH;
         di_m_q         <= 1'b0;
         din_s_q        <= 1'b0;
         hcnt_q         <= 8'd0;
         lcnt_q         <= 12'd0;
         bcnt_q         <= 5'd0;
         shift_q        <= '0;
         pidx_q         <= 8'd0;
         shadow_q       <= '0;
         strip_q        <= '0;
         pixel_data_q   <= 24'd0;
         pixel_index_q  <= 8'd0;
         frame_pixels_q <= 8'd0;
         pixel_valid_q  <= 1'b0;
         frame_done_q   <= 1'b0;
         error_q        <= 1'b0;
      end else begin
         state_q        <= state_d;
         di_m_q         <= di_m_d;
         din_s_q        <= din_s_d;
         hcnt_q         <= hcnt_d;
         lcnt_q         <= lcnt_d;
         bcnt_q         <= bcnt_d;
         shift_q        <= shift_d;
         pidx_q         <= pidx_d;
         shadow_q       <= shadow_d;
         strip_q        <= strip_d;
         pixel_data_q   <= pixel_data_d;
         pixel_index_q  <= pixel_index_d;
         frame_pixels_q <= frame_pixels_d;
         pixel_valid_q  <= pixel_valid_d;
         frame_done_q   <= frame_done_d;
         error_q        <= error_d;
      end
   end
   assign pixel_data   = pixel_data_q;
   assign pixel_valid  = pixel_valid_q;
   assign pixel_index  = pixel_index_q;
   assign strip        = strip_q;
   assign frame_done   = frame_done_q;
   assign frame_pixels = frame_pixels_q;
   assign error        = error_q;
endmodule

// File: tb/tb_ws2812_decoder.sv
// tb_ws2812_decoder: directed checks of pixel decoding, frame latching and error pulses.
module tb_ws2812_decoder;
   logic        clk = 1'b0, reset, DI;
   logic [23:0] pixel_data;
   logic        pixel_valid, frame_done, error;
   logic [7:0]  pixel_index, frame_pixels;
   logic [95:0] strip;
   int tests = 0, fails = 0;
   int n_pv = 0, n_fd = 0, n_err = 0, n_err_fd = 0, n_long = 0;
   logic [23:0] pd_q[$];
   logic [7:0]  pi_q[$];
   time pv_t = 0, fall_t = 0;
   logic pv_p = 1'b0, fd_p = 1'b0, er_p = 1'b0;
   always #5 clk = ~clk;
   ws2812_decoder dut (
      .clk(clk), .reset(reset), .DI(DI), .pixel_data(pixel_data), .pixel_valid(pixel_valid),
      .pixel_index(pixel_index), .strip(strip), .frame_done(frame_done),
      .frame_pixels(frame_pixels), .error(error)
   );
   always @(negedge clk) begin
      if (pixel_valid) begin
         n_pv++;
         pd_q.push_back(pixel_data);
         pi_q.push_back(pixel_index);
         pv_t = $time;
      end
      if (frame_done) n_fd++;
      if (error) n_err++;
      if (error && frame_done) n_err_fd++;
      if ((pixel_valid && pv_p) || (frame_done && fd_p) || (error && er_p)) n_long++;
      pv_p = pixel_valid;
      fd_p = frame_done;
      er_p = error;
   end
   task automatic cyc(input int n, input logic v);
      DI = v;
      repeat (n) @(negedge clk);
   endtask
   task automatic pulse(input int h, input int l);
      cyc(h, 1'b1);
      fall_t = $time;
      cyc(l, 1'b0);
   endtask
   task automatic send_bit(input logic b);
      pulse(b ? 40 : 20, b ? 21 : 41);
   endtask
   task automatic send_px(input logic [23:0] w);
      for (int i = 23; i >= 0; i--) send_bit(w[i]);
   endtask
   task automatic test_reset;
      reset = 1'b1;
      cyc(3, 1'b0);
      cyc(5, 1'b1);
      cyc(3, 1'b0);
      tests++; if (pixel_data !== 24'd0) begin fails++; $display("FAIL reset_pixel_data: got %h expected 0", pixel_data); end
      tests++; if (pixel_index !== 8'd0) begin fails++; $display("FAIL reset_pixel_index: got %h expected 0", pixel_index); end
      tests++; if (strip !== 96'd0) begin fails++; $display("FAIL reset_strip: got %h expected 0", strip); end
      tests++; if (frame_pixels !== 8'd0) begin fails++; $display("FAIL reset_frame_pixels: got %h expected 0", frame_pixels); end
      tests++; if ({pixel_valid, frame_done, error} !== 3'b000) begin fails++; $display("FAIL reset_pulses: got %b expected 000", {pixel_valid, frame_done, error}); end
      reset = 1'b0;
      cyc(2600, 1'b0);
   endtask
   task automatic test_frame;
      logic [23:0] exp [4] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFFFF};
      int pv0 = n_pv, fd0 = n_fd, er0 = n_err;
      pd_q.delete(); pi_q.delete();
      for (int i = 0; i < 4; i++) send_px(exp[i]);
      tests++; if (pv_t - fall_t !== 30) begin fails++; $display("FAIL frame_latency: got %0t expected 30", pv_t - fall_t); end
      cyc(2600, 1'b0);
      tests++; if (n_pv - pv0 !== 4) begin fails++; $display("FAIL frame_pv_count: got %0d expected 4", n_pv - pv0); end
      for (int i = 0; i < 4; i++) begin
         tests++; if (pi_q[i] !== 8'(i)) begin fails++; $display("FAIL frame_index%0d: got %0d expected %0d", i, pi_q[i], i); end
         tests++; if (pd_q[i] !== exp[i]) begin fails++; $display("FAIL frame_data%0d: got %h expected %h", i, pd_q[i], exp[i]); end
      end
      tests++; if (n_fd - fd0 !== 1) begin fails++; $display("FAIL frame_done_count: got %0d expected 1", n_fd - fd0); end
      tests++; if (n_err - er0 !== 0) begin fails++; $display("FAIL frame_errors: got %0d expected 0", n_err - er0); end
      tests++; if (strip !== 96'hFFFFFF_0000FF_00FF00_FF0000) begin fails++; $display("FAIL frame_strip: got %h expected FFFFFF0000FF00FF00FF0000", strip); end
      tests++; if (frame_pixels !== 8'd4) begin fails++; $display("FAIL frame_pixels: got %0d expected 4", frame_pixels); end
   endtask
   task automatic test_threshold;
      logic [21:0] rest = 22'h15A5A5;
      int er0 = n_err, fd0 = n_fd;
      pd_q.delete(); pi_q.delete();
      pulse(29, 32);
      pulse(30, 31);
      tests++; if (n_err - er0 !== 0) begin fails++; $display("FAIL thresh_no_error: got %0d expected 0", n_err - er0); end
      pulse(4, 57);
      tests++; if (n_err - er0 !== 1) begin fails++; $display("FAIL thresh_glitch_error: got %0d expected 1", n_err - er0); end
      for (int i = 21; i >= 0; i--) send_bit(rest[i]);
      tests++; if (pd_q[0] !== 24'h55A5A5) begin fails++; $display("FAIL thresh_word: got %h expected 55a5a5", pd_q[0]); end
      cyc(2600, 1'b0);
      tests++; if (n_fd - fd0 !== 1) begin fails++; $display("FAIL thresh_frame_done: got %0d expected 1", n_fd - fd0); end
      tests++; if (strip !== 96'hFFFFFF_0000FF_00FF00_55A5A5) begin fails++; $display("FAIL thresh_strip_retain: got %h expected FFFFFF0000FF00FF0055A5A5", strip); end
      tests++; if (frame_pixels !== 8'd1) begin fails++; $display("FAIL thresh_frame_pixels: got %0d expected 1", frame_pixels); end
   endtask
   task automatic test_overflow;
      int pv0 = n_pv;
      pd_q.delete(); pi_q.delete();
      for (int i = 1; i <= 6; i++) send_px(24'h111111 * 24'(i));
      cyc(2600, 1'b0);
      tests++; if (n_pv - pv0 !== 6) begin fails++; $display("FAIL ovf_pv_count: got %0d expected 6", n_pv - pv0); end
      tests++; if (pi_q[5] !== 8'd5 || pd_q[5] !== 24'h666666) begin fails++; $display("FAIL ovf_last_pixel: got %0d/%h expected 5/666666", pi_q[5], pd_q[5]); end
      tests++; if (strip !== 96'h444444_333333_222222_111111) begin fails++; $display("FAIL ovf_strip: got %h expected 444444333333222222111111", strip); end
      tests++; if (frame_pixels !== 8'd6) begin fails++; $display("FAIL ovf_frame_pixels: got %0d expected 6", frame_pixels); end
   endtask
   task automatic test_partial;
      int pv0 = n_pv, ef0 = n_err_fd, er0 = n_err;
      send_px(24'hABCDEF);
      for (int i = 0; i < 6; i++) send_bit(i[0]);
      cyc(2600, 1'b0);
      tests++; if (n_pv - pv0 !== 1) begin fails++; $display("FAIL partial_pv_count: got %0d expected 1", n_pv - pv0); end
      tests++; if (n_err_fd - ef0 !== 1) begin fails++; $display("FAIL partial_err_with_done: got %0d expected 1", n_err_fd - ef0); end
      tests++; if (n_err - er0 !== 1) begin fails++; $display("FAIL partial_err_count: got %0d expected 1", n_err - er0); end
      tests++; if (frame_pixels !== 8'd1) begin fails++; $display("FAIL partial_frame_pixels: got %0d expected 1", frame_pixels); end
      tests++; if (strip !== 96'h444444_333333_222222_ABCDEF) begin fails++; $display("FAIL partial_strip: got %h expected 444444333333222222abcdef", strip); end
   endtask
   task automatic test_stuck;
      int pv0 = n_pv, fd0 = n_fd, er0 = n_err;
      send_px(24'h123456);
      cyc(100, 1'b1);
      cyc(2600, 1'b0);
      tests++; if (n_err - er0 !== 1) begin fails++; $display("FAIL stuck_error: got %0d expected 1", n_err - er0); end
      tests++; if (n_fd - fd0 !== 0) begin fails++; $display("FAIL stuck_no_done: got %0d expected 0", n_fd - fd0); end
      tests++; if (n_pv - pv0 !== 1) begin fails++; $display("FAIL stuck_pv_count: got %0d expected 1", n_pv - pv0); end
      tests++; if (strip !== 96'h444444_333333_222222_ABCDEF) begin fails++; $display("FAIL stuck_strip_kept: got %h expected 444444333333222222abcdef", strip); end
      send_px(24'hC0FFEE); send_px(24'h010203); send_px(24'h0A0B0C); send_px(24'h808080);
      cyc(2600, 1'b0);
      tests++; if (n_fd - fd0 !== 1) begin fails++; $display("FAIL stuck_recover_done: got %0d expected 1", n_fd - fd0); end
      tests++; if (strip !== 96'h808080_0A0B0C_010203_C0FFEE) begin fails++; $display("FAIL stuck_recover_strip: got %h expected 8080800a0b0c010203c0ffee", strip); end
      tests++; if (frame_pixels !== 8'd4) begin fails++; $display("FAIL stuck_recover_pixels: got %0d expected 4", frame_pixels); end
   endtask
   task automatic test_reset_mid;
      int pv0, fd0;
      for (int i = 0; i < 12; i++) send_bit(1'b1);
      reset = 1'b1;
      cyc(3, 1'b0);
      tests++; if (strip !== 96'd0) begin fails++; $display("FAIL mid_reset_strip: got %h expected 0", strip); end
      tests++; if (frame_pixels !== 8'd0 || pixel_index !== 8'd0) begin fails++; $display("FAIL mid_reset_counts: got %0d/%0d expected 0/0", frame_pixels, pixel_index); end
      reset = 1'b0;
      pv0 = n_pv; fd0 = n_fd;
      send_px(24'hFFFFFF);
      cyc(2600, 1'b0);
      tests++; if (n_pv - pv0 !== 0) begin fails++; $display("FAIL mid_ignored_pv: got %0d expected 0", n_pv - pv0); end
      tests++; if (n_fd - fd0 !== 0) begin fails++; $display("FAIL mid_ignored_done: got %0d expected 0", n_fd - fd0); end
      tests++; if (strip !== 96'd0) begin fails++; $display("FAIL mid_strip_zero: got %h expected 0", strip); end
      send_px(24'h5A5A5A);
      cyc(2600, 1'b0);
      tests++; if (strip !== 96'h000000_000000_000000_5A5A5A) begin fails++; $display("FAIL mid_after_strip: got %h expected 5a5a5a", strip); end
      tests++; if (frame_pixels !== 8'd1) begin fails++; $display("FAIL mid_after_pixels: got %0d expected 1", frame_pixels); end
   endtask
   initial begin
      DI = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      test_reset;
      test_frame;
      test_threshold;
      test_overflow;
      test_partial;
      test_stuck;
      test_reset_mid;
      tests++; if (n_long !== 0) begin fails++; $display("FAIL pulse_width: got %0d long pulses expected 0", n_long); end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
